noc_axi4lite_bridge: RTL and testbench

NOC_AXI4LITE_BRIDGE -- requirements
Module: noc_axi4lite_bridge

---
 rtl/noc_axi4lite_bridge_if.sv | 56 +++++
 rtl/noc_axi4lite_bridge.sv | 181 ++++++++++++++++++
 tb/tb_noc_axi4lite_bridge.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_axi4lite_bridge_if.sv
// AXI4-Lite slave and NoC endpoint signals of the bridge.
// The bridge takes the slave modport, the driving side takes master.
interface noc_axi4lite_bridge_if #(
  parameter int BUS_W = 66
);
  logic [31:0]      axi_awaddr_i;
  logic             axi_awvalid_i;
  logic             axi_awready_o;
  logic [31:0]      axi_wdata_i;
  logic [3:0]       axi_wstrb_i;
  logic             axi_wvalid_i;
  logic             axi_wready_o;
  logic [1:0]       axi_bresp_o;
  logic             axi_bvalid_o;
  logic             axi_bready_i;
  logic [31:0]      axi_araddr_i;
  logic             axi_arvalid_i;
  logic             axi_arready_o;
  logic [31:0]      axi_rdata_o;
  logic [1:0]       axi_rresp_o;
  logic             axi_rvalid_o;
  logic             axi_rready_i;
  logic [BUS_W-1:0] noc_din_o;
  logic             noc_wr_o;
  logic             noc_wait_i;
  logic [BUS_W-1:0] noc_dout_i;
  logic             noc_nd_i;
  logic             noc_rd_o;
  logic             noc_int_o;

  modport slave (
    input  axi_awaddr_i, axi_awvalid_i,
    input  axi_wdata_i, axi_wstrb_i, axi_wvalid_i,
    input  axi_bready_i,
    input  axi_araddr_i, axi_arvalid_i, axi_rready_i,
    input  noc_wait_i, noc_dout_i, noc_nd_i,
    output axi_awready_o, axi_wready_o,
    output axi_bresp_o, axi_bvalid_o,
    output axi_arready_o, axi_rdata_o,
    output axi_rresp_o, axi_rvalid_o,
    output noc_din_o, noc_wr_o, noc_rd_o, noc_int_o
  );

  modport master (
    output axi_awaddr_i, axi_awvalid_i,
    output axi_wdata_i, axi_wstrb_i, axi_wvalid_i,
    output axi_bready_i,
    output axi_araddr_i, axi_arvalid_i, axi_rready_i,
    output noc_wait_i, noc_dout_i, noc_nd_i,
    input  axi_awready_o, axi_wready_o,
    input  axi_bresp_o, axi_bvalid_o,
    input  axi_arready_o, axi_rdata_o,
    input  axi_rresp_o, axi_rvalid_o,
    input  noc_din_o, noc_wr_o, noc_rd_o, noc_int_o
  );
endinterface

// File: rtl/noc_axi4lite_bridge.sv
// AXI4-Lite register window onto a NoC endpoint:
// one TX packet register set and an RX packet FIFO.
module noc_axi4lite_bridge #(
  parameter int NOC_X          = 0,
  parameter int NOC_Y          = 0,
  parameter int SOC_SIZE_X     = 1,
  parameter int SOC_SIZE_Y     = 1,
  parameter int NOC_DATA_WIDTH = 56,
  parameter int RX_DEPTH_LOG2  = 2
) (
  input logic clk_i,
  input logic rst_n_i,
  noc_axi4lite_bridge_if.slave bus
);
  localparam int HDR_W = 2*SOC_SIZE_X + 2*SOC_SIZE_Y + 6;
  localparam int BUS_W = NOC_DATA_WIDTH + HDR_W;
  localparam int HI_W  = NOC_DATA_WIDTH - 32;
  localparam int DEPTH = 1 << RX_DEPTH_LOG2;
  localparam int CW    = RX_DEPTH_LOG2 + 1;

  localparam logic [2:0] A_TX_LO  = 3'd0;
  localparam logic [2:0] A_TX_HI  = 3'd1;
  localparam logic [2:0] A_TX_HDR = 3'd2;
  localparam logic [2:0] A_RX_LO  = 3'd3;
  localparam logic [2:0] A_RX_HI  = 3'd4;
  localparam logic [2:0] A_RX_HDR = 3'd5;
  localparam logic [2:0] A_STATUS = 3'd6;
  localparam logic [2:0] A_IRQ_EN = 3'd7;

  localparam logic [CW-1:0] CNT_FULL = DEPTH[CW-1:0];
  localparam logic [CW-1:0] CNT_ONE  = 1;
  localparam logic [RX_DEPTH_LOG2-1:0] PTR_ONE = 1;

  logic [31:0]              r_tx_lo;
  logic [HI_W-1:0]          r_tx_hi;
  logic                     r_irq_en;
  logic                     r_tx_busy;
  logic [BUS_W-1:0]         r_din;
  logic                     r_bvalid;
  logic [1:0]               r_bresp;
  logic                     r_rvalid;
  logic [31:0]              r_rdata;
  logic                     r_int;
  logic [BUS_W-1:0]         r_mem [DEPTH];
  logic [RX_DEPTH_LOG2-1:0] r_wptr;
  logic [RX_DEPTH_LOG2-1:0] r_rptr;
  logic [CW-1:0]            r_count;

  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_wr_err;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_nempty;
  logic [2:0]       w_waddr;
  logic [2:0]       w_raddr;
  logic [BUS_W-1:0] w_head;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_waddr  = bus.axi_awaddr_i[4:2];
  assign w_raddr  = bus.axi_araddr_i[4:2];
  assign w_full   = (r_count == CNT_FULL);
  assign w_nempty = (r_count != '0);
  assign w_head   = w_nempty ? r_mem[r_rptr] : '0;

  // Ready/accept terms are gated so nothing handshakes during reset.
  assign w_wr_acc = rst_n_i & bus.axi_awvalid_i
                  & bus.axi_wvalid_i & ~r_bvalid;
  assign w_rd_acc = rst_n_i & bus.axi_arvalid_i & ~r_rvalid;
  assign w_push   = rst_n_i & bus.noc_nd_i & ~w_full;
  assign w_pop    = w_rd_acc & (w_raddr == A_RX_HDR) & w_nempty;

  assign w_wr_err = (w_waddr <= A_TX_HDR) ? r_tx_busy
                                          : (w_waddr != A_IRQ_EN);

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_raddr == A_TX_LO:  w_rdata = r_tx_lo;
      w_raddr == A_TX_HI:  w_rdata = 32'(r_tx_hi);
      w_raddr == A_RX_LO:  w_rdata = w_head[31:0];
      w_raddr == A_RX_HI:
        w_rdata = 32'(w_head[NOC_DATA_WIDTH-1:32]);
      w_raddr == A_RX_HDR:
        w_rdata = 32'(w_head[BUS_W-1:NOC_DATA_WIDTH]);
      w_raddr == A_STATUS: begin
        w_rdata[8 +: CW] = r_count;
        w_rdata[2:0]     = {r_tx_busy, w_full, w_nempty};
      end
      w_raddr == A_IRQ_EN: w_rdata[0] = r_irq_en;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_bvalid <= 1'b0;
      r_bresp  <= 2'b00;
      r_tx_lo  <= '0;
      r_tx_hi  <= '0;
      r_irq_en <= 1'b0;
    end else if (w_wr_acc) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_wr_err ? 2'b10 : 2'b00;
      if (!w_wr_err) begin
        if (w_waddr == A_TX_LO) r_tx_lo <= bus.axi_wdata_i;
        if (w_waddr == A_TX_HI)
          r_tx_hi <= bus.axi_wdata_i[HI_W-1:0];
        if (w_waddr == A_IRQ_EN) r_irq_en <= bus.axi_wdata_i[0];
      end
    end else if (bus.axi_bready_i) begin
      r_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_int    <= 1'b0;
    end else begin
      r_int <= r_irq_en & w_nempty;
      if (w_rd_acc) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata;
      end else if (bus.axi_rready_i) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Launch cannot overlap a pending send: w_wr_err blocks it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_tx_busy <= 1'b0;
      r_din     <= '0;
    end else if (w_wr_acc && !w_wr_err && w_waddr == A_TX_HDR) begin
      r_tx_busy <= 1'b1;
      r_din <= {bus.axi_wdata_i[HDR_W-1:0], r_tx_hi, r_tx_lo};
    end else if (!bus.noc_wait_i) begin
      r_tx_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= bus.noc_dout_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
    end
  end

  assign bus.axi_awready_o = w_wr_acc;
  assign bus.axi_wready_o  = w_wr_acc;
  assign bus.axi_bvalid_o  = r_bvalid;
  assign bus.axi_bresp_o   = r_bresp;
  assign bus.axi_arready_o = w_rd_acc;
  assign bus.axi_rvalid_o  = r_rvalid;
  assign bus.axi_rdata_o   = r_rdata;
  assign bus.axi_rresp_o   = 2'b00;
  assign bus.noc_din_o     = r_din;
  assign bus.noc_wr_o      = r_tx_busy;
  assign bus.noc_rd_o      = w_push;
  assign bus.noc_int_o     = r_int;

  assign w_unused = ^{bus.axi_wstrb_i,
                      bus.axi_awaddr_i[31:5], bus.axi_awaddr_i[1:0],
                      bus.axi_araddr_i[31:5], bus.axi_araddr_i[1:0],
                      NOC_X[0], NOC_Y[0]};
endmodule

// File: tb/tb_noc_axi4lite_bridge.sv
// Randomized bench for noc_axi4lite_bridge against a queue-based
// reference model, plus directed packet/FIFO/IRQ/reset scenarios.
module tb_noc_axi4lite_bridge;
  localparam int HDR_W = 10;
  localparam int BUS_W = 66;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  noc_axi4lite_bridge_if #(.BUS_W(BUS_W)) bus ();
  noc_axi4lite_bridge dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;
  int rd_cnt  = 0;
  logic [BUS_W-1:0] last_din = '0;

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", nm, got, exp,
               $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s timed out t=%0t", nm, $time);
  endtask

  // Reference model: registers as plain values, RX FIFO as a queue.
  logic             m_bvalid = 0, m_rvalid = 0, m_busy = 0;
  logic             m_irq = 0, m_int = 0;
  logic [1:0]       m_bresp = 0;
  logic [31:0]      m_rdata = 0, m_lo = 0;
  logic [23:0]      m_hi = 0;
  logic [BUS_W-1:0] m_din = '0;
  logic [BUS_W-1:0] m_q[$];

  always @(posedge clk or negedge rst_n) begin
    logic wacc, racc, push, pop, werr, nint;
    logic [2:0] wa, ra;
    logic [BUS_W-1:0] head;
    logic [31:0] rd;
    int sz;
    if (!rst_n) begin
      m_bvalid = 0; m_rvalid = 0; m_busy = 0; m_irq = 0;
      m_int = 0; m_bresp = 0; m_rdata = 0; m_lo = 0;
      m_hi = 0; m_din = '0;
      m_q.delete();
    end else begin
      sz   = m_q.size();
      wa   = bus.axi_awaddr_i[4:2];
      ra   = bus.axi_araddr_i[4:2];
      wacc = bus.axi_awvalid_i && bus.axi_wvalid_i && !m_bvalid;
      racc = bus.axi_arvalid_i && !m_rvalid;
      push = bus.noc_nd_i && (sz < DEPTH);
      pop  = racc && (ra == 3'd5) && (sz > 0);
      head = (sz > 0) ? m_q[0] : '0;
      werr = (wa <= 3'd2) ? m_busy : (wa != 3'd7);
      nint = m_irq && (sz > 0);
      case (ra)
        3'd0: rd = m_lo;
        3'd1: rd = {8'h0, m_hi};
        3'd3: rd = head[31:0];
        3'd4: rd = {8'h0, head[55:32]};
        3'd5: rd = {22'h0, head[65:56]};
        3'd6: rd = 32'(sz * 256 + (m_busy ? 4 : 0)
                   + (sz == DEPTH ? 2 : 0) + (sz > 0 ? 1 : 0));
        3'd7: rd = {31'h0, m_irq};
        default: rd = '0;
      endcase
      if (wacc && !werr && wa == 3'd2) begin
        m_busy = 1;
        m_din  = {bus.axi_wdata_i[HDR_W-1:0], m_hi, m_lo};
      end else if (!bus.noc_wait_i) begin
        m_busy = 0;
      end
      if (wacc) begin
        m_bvalid = 1;
        m_bresp  = werr ? 2'b10 : 2'b00;
        if (!werr && wa == 3'd0) m_lo = bus.axi_wdata_i;
        if (!werr && wa == 3'd1) m_hi = bus.axi_wdata_i[23:0];
        if (!werr && wa == 3'd7) m_irq = bus.axi_wdata_i[0];
      end else if (bus.axi_bready_i) begin
        m_bvalid = 0;
      end
      if (racc) begin
        m_rvalid = 1;
        m_rdata  = rd;
      end else if (bus.axi_rready_i) begin
        m_rvalid = 0;
      end
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(bus.noc_dout_i);
      m_int = nint;
    end
  end

  always @(negedge clk) begin
    logic room;
    room = (m_q.size() < DEPTH);
    chk("awready", bus.axi_awready_o, rst_n && bus.axi_awvalid_i
        && bus.axi_wvalid_i && !m_bvalid);
    chk("wready", bus.axi_wready_o, rst_n && bus.axi_awvalid_i
        && bus.axi_wvalid_i && !m_bvalid);
    chk("arready", bus.axi_arready_o,
        rst_n && bus.axi_arvalid_i && !m_rvalid);
    chk("bvalid", bus.axi_bvalid_o, m_bvalid);
    chk("rvalid", bus.axi_rvalid_o, m_rvalid);
    if (m_bvalid || !rst_n) chk("bresp", bus.axi_bresp_o, m_bresp);
    if (m_rvalid || !rst_n) begin
      chk("rdata", bus.axi_rdata_o, m_rdata);
      chk("rresp", bus.axi_rresp_o, 2'b00);
    end
    chk("noc_wr", bus.noc_wr_o, m_busy);
    if (m_busy || !rst_n) chk("noc_din", bus.noc_din_o, m_din);
    chk("noc_rd", bus.noc_rd_o, rst_n && bus.noc_nd_i && room);
    chk("noc_int", bus.noc_int_o, m_int);
    if (bus.noc_wr_o) begin
      wr_cnt++;
      last_din = bus.noc_din_o;
    end
    if (bus.noc_rd_o) rd_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_wr(input logic [31:0] a, input logic [31:0] d,
                        output logic [1:0] resp);
    int n;
    resp = 2'b11;
    bus.axi_awaddr_i  = a;
    bus.axi_wdata_i   = d;
    bus.axi_awvalid_i = 1'b1;
    bus.axi_wvalid_i  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.axi_awready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) timeout("aw_handshake");
    tick();
    bus.axi_awvalid_i = 1'b0;
    bus.axi_wvalid_i  = 1'b0;
    bus.axi_bready_i  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.axi_bvalid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) timeout("b_handshake");
    resp = bus.axi_bresp_o;
    tick();
    bus.axi_bready_i = 1'b0;
  endtask

  task automatic axi_rd(input logic [31:0] a, output logic [31:0] d,
                        output logic [1:0] resp);
    int n;
    d = 32'hFFFF_FFFF;
    resp = 2'b11;
    bus.axi_araddr_i  = a;
    bus.axi_arvalid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.axi_arready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) timeout("ar_handshake");
    tick();
    bus.axi_arvalid_i = 1'b0;
    bus.axi_rready_i  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.axi_rvalid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) timeout("r_handshake");
    d = bus.axi_rdata_o;
    resp = bus.axi_rresp_o;
    tick();
    bus.axi_rready_i = 1'b0;
  endtask

  function automatic logic [BUS_W-1:0] mk(input int i);
    return {10'(i + 1), 24'(i + 32'hA0), 32'(32'h1000 + i)};
  endfunction

  initial begin
    logic [1:0] resp;
    logic [31:0] rd;
    logic [BUS_W-1:0] p;
    int w0, r0, n;
    int ids[4];
    ids = '{1, 2, 3, 9};
    bus.axi_awaddr_i = '0; bus.axi_awvalid_i = 0;
    bus.axi_wdata_i = '0; bus.axi_wstrb_i = 4'hF;
    bus.axi_wvalid_i = 0; bus.axi_bready_i = 0;
    bus.axi_araddr_i = '0; bus.axi_arvalid_i = 0;
    bus.axi_rready_i = 0; bus.noc_wait_i = 0;
    bus.noc_dout_i = '0; bus.noc_nd_i = 0;
    repeat (3) tick();
    chk("rst_noc_din", bus.noc_din_o, 0);
    chk("rst_rdata", bus.axi_rdata_o, 0);
    rst_n = 1'b1;
    tick();

    axi_wr(32'h0, 32'h1122_3344, resp);
    chk("txlo_resp", resp, 2'b00);
    axi_wr(32'h4, 32'h00AA_BBCC, resp);
    w0 = wr_cnt;
    axi_wr(32'h8, 32'h2A, resp);
    chk("txhdr_resp", resp, 2'b00);
    repeat (3) tick();
    chk("send_cycles", 32'(wr_cnt - w0), 1);
    chk("send_din", last_din, {10'h02A, 56'hAABBCC_11223344});

    bus.noc_wait_i = 1'b1;
    w0 = wr_cnt;
    axi_wr(32'h8, 32'h155, resp);
    axi_wr(32'h0, 32'hDEAD_BEEF, resp);
    chk("busy_txlo_slverr", resp, 2'b10);
    n = 0;
    while (wr_cnt - w0 < 5 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (n >= 50) timeout("wait_send");
    #1;
    bus.noc_wait_i = 1'b0;
    repeat (3) tick();
    chk("wait_cycles", 32'(wr_cnt - w0), 6);
    chk("wait_din", last_din, {10'h155, 56'hAABBCC_11223344});
    axi_rd(32'h0, rd, resp);
    chk("txlo_kept", rd, 32'h1122_3344);

    r0 = rd_cnt;
    for (int i = 0; i < 6; i++) begin
      bus.noc_dout_i = mk(i);
      bus.noc_nd_i = 1'b1;
      tick();
    end
    bus.noc_nd_i = 1'b0;
    tick();
    chk("fill_rd_cycles", 32'(rd_cnt - r0), 4);
    axi_rd(32'h18, rd, resp);
    chk("status_full", rd, 32'h0000_0403);
    axi_rd(32'h14, rd, resp);
    chk("pop_hdr0", rd, 32'h1);
    axi_rd(32'h18, rd, resp);
    chk("status_3", rd, 32'h0000_0301);
    r0 = rd_cnt;
    bus.noc_dout_i = mk(9);
    bus.noc_nd_i = 1'b1;
    repeat (3) tick();
    bus.noc_nd_i = 1'b0;
    tick();
    chk("refill_rd", 32'(rd_cnt - r0), 1);
    axi_rd(32'hC, rd, resp);
    chk("head1_lo", rd, 32'h0000_1001);
    for (int j = 0; j < 4; j++) begin
      p = mk(ids[j]);
      axi_rd(32'hC, rd, resp);
      chk("drain_lo", rd, p[31:0]);
      axi_rd(32'h10, rd, resp);
      chk("drain_hi", rd, {8'h0, p[55:32]});
      axi_rd(32'h14, rd, resp);
      chk("drain_hdr", rd, {22'h0, p[65:56]});
    end
    axi_rd(32'h18, rd, resp);
    chk("status_empty", rd, 32'h0);

    axi_wr(32'h1C, 32'h1, resp);
    bus.noc_dout_i = mk(5);
    bus.noc_nd_i = 1'b1;
    tick();
    bus.noc_nd_i = 1'b0;
    @(negedge clk);
    chk("int_not_yet", bus.noc_int_o, 1'b0);
    tick();
    @(negedge clk);
    chk("int_high", bus.noc_int_o, 1'b1);
    tick();
    axi_rd(32'h14, rd, resp);
    chk("int_pkt_hdr", rd, 32'h6);
    repeat (2) tick();
    chk("int_low", bus.noc_int_o, 1'b0);
    axi_rd(32'hC, rd, resp);
    chk("empty_rxlo", rd, 32'h0);
    chk("empty_rxlo_resp", resp, 2'b00);

    axi_wr(32'h18, 32'h5, resp);
    chk("status_wr_slverr", resp, 2'b10);
    bus.noc_nd_i = 1'b1;
    repeat (6) tick();
    bus.noc_wait_i = 1'b1;
    axi_wr(32'h8, 32'h3FF, resp);
    bus.axi_araddr_i = 32'h18;
    bus.axi_arvalid_i = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_wr", bus.noc_wr_o, 1'b0);
    chk("rst_rd", bus.noc_rd_o, 1'b0);
    chk("rst_int", bus.noc_int_o, 1'b0);
    chk("rst_rvalid", bus.axi_rvalid_o, 1'b0);
    chk("rst_arready", bus.axi_arready_o, 1'b0);
    chk("rst_din", bus.noc_din_o, 0);
    chk("rst_rdata_mid", bus.axi_rdata_o, 0);
    bus.axi_arvalid_i = 1'b0;
    bus.noc_nd_i = 1'b0;
    bus.noc_wait_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    axi_rd(32'h18, rd, resp);
    chk("status_after_rst", rd, 32'h0);
    axi_rd(32'h1C, rd, resp);
    chk("irq_after_rst", rd, 32'h0);

    for (int c = 0; c < 4000; c++) begin
      bus.axi_awvalid_i = ($urandom_range(0, 3) == 0);
      bus.axi_wvalid_i  = bus.axi_awvalid_i ?
                          ($urandom_range(0, 3) != 0) :
                          ($urandom_range(0, 7) == 0);
      bus.axi_awaddr_i  = $urandom;
      bus.axi_wdata_i   = $urandom;
      bus.axi_bready_i  = ($urandom_range(0, 1) == 0);
      bus.axi_arvalid_i = ($urandom_range(0, 2) == 0);
      bus.axi_araddr_i  = $urandom;
      bus.axi_rready_i  = ($urandom_range(0, 1) == 0);
      bus.noc_wait_i    = ($urandom_range(0, 2) != 0);
      bus.noc_nd_i      = ($urandom_range(0, 1) == 0);
      bus.noc_dout_i    = BUS_W'({$urandom, $urandom, $urandom});
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_n = 1'b1;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
